// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (double-dabble, one input bit per clock); optional BCD_SEQ_BLANK_EN adds leading-zero blank_mask.
// Latency: out_valid rises WIDTH edges after the accepting edge; one conversion per WIDTH+2 cycles at best.
// Backpressure: in_ready only in IDLE; result, overflow and blank_mask are held in DONE until out_ready.
module bcd_seq_converter #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic                  busy
`ifdef BCD_SEQ_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank_mask
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [WIDTH-1:0]      shift_reg, shift_nxt;
  logic [4*DIGITS-1:0]   digits, digits_adj, digits_nxt;
  logic                  carry_out;
  logic [CW-1:0]         count;
  logic                  ovf;
  logic                  accept;
  logic                  last_iter;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = CONVERT;
        end
      end
      CONVERT: begin
        busy = 1'b1;
        if (count == CW'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One double-dabble iteration: add 3 to digits >= 5, then shift {digits, shift_reg} left.
  // Whatever leaves the top digit is a multiple of 10^DIGITS, so the digits keep value mod 10^DIGITS.
  always_comb begin
    digits_adj = digits;
    for (int k = 0; k < DIGITS; k++) begin
      if (digits[4*k +: 4] >= 4'd5) begin
        digits_adj[4*k +: 4] = digits[4*k +: 4] + 4'd3;
      end
    end
    {carry_out, digits_nxt, shift_nxt} = {digits_adj, shift_reg, 1'b0};
    last_iter = (state == CONVERT) && (count == CW'(1));
  end

  // Datapath: load on accept, iterate while converting, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      digits    <= '0;
      ovf       <= 1'b0;
      count     <= '0;
    end else if (accept) begin
      shift_reg <= bin_in;
      digits    <= '0;
      ovf       <= 1'b0;
      count     <= CW'(WIDTH);
    end else if (state == CONVERT) begin
      shift_reg <= shift_nxt;
      digits    <= digits_nxt;
      ovf       <= ovf | carry_out;
      count     <= count - CW'(1);
    end
  end

  assign bcd_out  = digits;
  assign overflow = ovf;

`ifdef BCD_SEQ_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;
  logic              hi_zero;

  // Leading-zero mask from the final digits; ones digit never blanked, nothing blanked on overflow
  always_comb begin
    blank_nxt = '0;
    hi_zero   = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      hi_zero      = hi_zero & (digits_nxt[4*k +: 4] == 4'd0);
      blank_nxt[k] = hi_zero;
    end
    if (ovf | carry_out) begin
      blank_nxt = '0;
    end
  end

  // Capture the mask on the edge that enters DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_mask <= '0;
    end else if (last_iter) begin
      blank_mask <= blank_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed bench for bcd_seq_converter: a 10-bit/4-digit instance and an 8-bit/2-digit instance.
// Checks latency, busy span, results, overflow, backpressure hold, async reset abort and optional blank_mask.
// All expected values are hand-computed constants.
module tb_bcd_seq_converter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: WIDTH=10, DIGITS=4
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ov, a_busy;
  logic [9:0]  a_bin;
  logic [15:0] a_bcd;
  // Instance B: WIDTH=8, DIGITS=2
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ov, b_busy;
  logic [7:0]  b_bin;
  logic [7:0]  b_bcd;
`ifdef BCD_SEQ_BLANK_EN
  logic [3:0]  a_blank;
  logic [1:0]  b_blank;
`endif

  bcd_seq_converter #(.WIDTH(10), .DIGITS(4)) u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .bin_in    (a_bin),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .bcd_out   (a_bcd),
    .overflow  (a_ov),
    .busy      (a_busy)
`ifdef BCD_SEQ_BLANK_EN
    ,
    .blank_mask(a_blank)
`endif
  );

  bcd_seq_converter #(.WIDTH(8), .DIGITS(2)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .bin_in    (b_bin),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .bcd_out   (b_bcd),
    .overflow  (b_ov),
    .busy      (b_busy)
`ifdef BCD_SEQ_BLANK_EN
    ,
    .blank_mask(b_blank)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept v on A and wait (bounded) for out_valid; checks latency and busy span
  task automatic start_a(input logic [9:0] v);
    int n;
    int busy_cnt;
    check("a_in_ready_pre", a_in_ready, 1);
    a_bin      = v;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (!a_out_valid && n < 40) begin
      busy_cnt += int'(a_busy);
      tick();
      n++;
    end
    check("a_latency", n, 10);
    check("a_busy_cycles", busy_cnt, 10);
    check("a_busy_done", a_busy, 0);
    check("a_in_ready_done", a_in_ready, 0);
  endtask

  task automatic release_a();
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    check("a_out_valid_drop", a_out_valid, 0);
    check("a_in_ready_back", a_in_ready, 1);
  endtask

  task automatic conv_a(input string tag, input logic [9:0] v, input logic [15:0] exp_bcd,
                        input logic exp_ov, input logic [3:0] exp_blank);
    start_a(v);
    check({tag, "_bcd"}, a_bcd, exp_bcd);
    check({tag, "_ov"}, a_ov, exp_ov);
`ifdef BCD_SEQ_BLANK_EN
    check({tag, "_blank"}, a_blank, exp_blank);
`endif
    release_a();
    check({tag, "_bcd_kept"}, a_bcd, exp_bcd);
  endtask

  task automatic conv_b(input string tag, input logic [7:0] v, input logic [7:0] exp_bcd,
                        input logic exp_ov, input logic [1:0] exp_blank);
    int n;
    check({tag, "_rdy_pre"}, b_in_ready, 1);
    b_bin      = v;
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 8);
    check({tag, "_bcd"}, b_bcd, exp_bcd);
    check({tag, "_ov"}, b_ov, exp_ov);
`ifdef BCD_SEQ_BLANK_EN
    check({tag, "_blank"}, b_blank, exp_blank);
`endif
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    check({tag, "_vld_drop"}, b_out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_bin = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_bin = '0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_bcd", a_bcd, 16'h0000);
    check("rst_ov", a_ov, 0);
`ifdef BCD_SEQ_BLANK_EN
    check("rst_blank", a_blank, 4'b0000);
`endif
    rst_n = 1'b1;
    tick();

    // Main function, WIDTH=10 DIGITS=4
    conv_a("a1023", 10'd1023, 16'h1023, 1'b0, 4'b0000);
    conv_a("a0",    10'd0,    16'h0000, 1'b0, 4'b1110);
    conv_a("a512",  10'd512,  16'h0512, 1'b0, 4'b1000);
    conv_a("a7",    10'd7,    16'h0007, 1'b0, 4'b1110);
    conv_a("a305",  10'd305,  16'h0305, 1'b0, 4'b1000);

    // Truncation and overflow, WIDTH=8 DIGITS=2
    conv_b("b255", 8'd255, 8'h55, 1'b1, 2'b00);
    conv_b("b99",  8'd99,  8'h99, 1'b0, 2'b00);
    conv_b("b100", 8'd100, 8'h00, 1'b1, 2'b00);
    conv_b("b5",   8'd5,   8'h05, 1'b0, 2'b10);

    // Backpressure: hold the result 6 cycles with a stray in_valid pulse
    start_a(10'd347);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        a_in_valid = 1'b1;
        a_bin      = 10'd5;
      end
      if (i == 3) begin
        a_in_valid = 1'b0;
      end
      tick();
      check("hold_out_valid", a_out_valid, 1);
      check("hold_bcd", a_bcd, 16'h0347);
      check("hold_ov", a_ov, 0);
      check("hold_in_ready", a_in_ready, 0);
    end
    release_a();
    conv_a("a512b", 10'd512, 16'h0512, 1'b0, 4'b1000);

    // Asynchronous reset 4 cycles into converting 900
    a_bin      = 10'd900;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    repeat (4) tick();
    check("abort_busy_before", a_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", a_busy, 0);
    check("abort_in_ready", a_in_ready, 1);
    check("abort_out_valid", a_out_valid, 0);
    check("abort_bcd", a_bcd, 16'h0000);
    check("abort_ov", a_ov, 0);
    repeat (4) tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", a_in_ready, 1);
    check("post_rst_out_valid", a_out_valid, 0);
    conv_a("a77", 10'd77, 16'h0077, 1'b0, 4'b1100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
